// File: rtl/ram_host_arbiter.sv
// ram_host_arbiter
//   Shares the single data port of a dual-port RAM between NR_HOSTS bus
//   hosts using a round-robin req/gnt/rvalid handshake. At most one
//   transaction is outstanding. Each transaction takes RD_LATENCY+1 cycles:
//   one grant cycle plus RD_LATENCY wait cycles. The completion pulse comes
//   in the last wait cycle.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active low
//   host_req_i     per-host request, held until granted
//   host_we_i      per-host write enable
//   host_addr_i    per-host address, host h at [h*ADDR_WIDTH +: ADDR_WIDTH]
//   host_wdata_i   per-host write data, same slicing as addresses
//   host_gnt_o     one-hot grant, combinational, in the accept cycle
//   host_rvalid_o  one-hot completion pulse to the transaction owner
//   host_rdata_o   read data (zero for writes), valid with host_rvalid_o
//   dev_we_o       RAM write enable
//   dev_addr_o     RAM address
//   dev_wdata_o    RAM write data
//   dev_rdata_i    RAM read data
//   busy_o         high while a transaction is outstanding
module ram_host_arbiter #(
  parameter int NR_HOSTS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_HOSTS-1:0]            host_req_i,
  input  logic [NR_HOSTS-1:0]            host_we_i,
  input  logic [NR_HOSTS*ADDR_WIDTH-1:0] host_addr_i,
  input  logic [NR_HOSTS*DATA_WIDTH-1:0] host_wdata_i,
  output logic [NR_HOSTS-1:0]            host_gnt_o,
  output logic [NR_HOSTS-1:0]            host_rvalid_o,
  output logic [DATA_WIDTH-1:0]          host_rdata_o,
  output logic                           dev_we_o,
  output logic [ADDR_WIDTH-1:0]          dev_addr_o,
  output logic [DATA_WIDTH-1:0]          dev_wdata_o,
  input  logic [DATA_WIDTH-1:0]          dev_rdata_i,
  output logic                           busy_o
);

  localparam int PTR_W = $clog2(NR_HOSTS);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic                  owner_we_q, owner_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W:0]        cand_sum;
  logic [PTR_W-1:0]      cand_idx;

  // Circular scan starting at rr_ptr; the first requester wins. Requests are
  // masked while reset is asserted so no grant leaks out during reset.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int i = 0; i < NR_HOSTS; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NR_HOSTS)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NR_HOSTS);
      end
      cand_idx = cand_sum[PTR_W-1:0];
      if (!win_found && rst_i && host_req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    owner_we_d    = owner_we_q;
    addr_d        = addr_q;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    dev_we_o      = 1'b0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    busy_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          host_gnt_o[win_idx] = 1'b1;
          dev_we_o            = host_we_i[win_idx];
          dev_addr_o          = host_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          dev_wdata_o         = host_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
          owner_d             = win_idx;
          owner_we_d          = host_we_i[win_idx];
          addr_d              = host_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          rr_ptr_d            = (win_idx == PTR_W'(NR_HOSTS-1)) ? '0 : win_idx + PTR_W'(1);
          cnt_d               = CNT_W'(RD_LATENCY);
          state_d             = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy_o     = 1'b1;
        // Keep the address stable so a RAM that samples late still sees it.
        dev_addr_o = addr_q;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          host_rvalid_o[owner_q] = 1'b1;
          host_rdata_o           = owner_we_q ? '0 : dev_rdata_i;
          state_d                = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
      owner_we_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed testbench for ram_host_arbiter. Two instances: dut1 with
// RD_LATENCY=1 and dut3 with RD_LATENCY=3, each attached to a small RAM model.
module tb_ram_host_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM preload port shared by both RAM models
  logic        pre_we  = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  // ---------------- dut1: RD_LATENCY = 1 ----------------
  logic        rst1 = 1'b0;
  logic [1:0]  req1 = '0, we1 = '0;
  logic [63:0] addr1 = '0, wdata1 = '0;
  logic [1:0]  gnt1, rvalid1;
  logic [31:0] rdata1, daddr1, dwdata1, drdata1;
  logic        dwe1, busy1;
  logic [31:0] mem1 [0:1023];

  ram_host_arbiter #(.NR_HOSTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .host_req_i(req1), .host_we_i(we1),
    .host_addr_i(addr1), .host_wdata_i(wdata1), .host_gnt_o(gnt1),
    .host_rvalid_o(rvalid1), .host_rdata_o(rdata1), .dev_we_o(dwe1),
    .dev_addr_o(daddr1), .dev_wdata_o(dwdata1), .dev_rdata_i(drdata1),
    .busy_o(busy1)
  );

  always @(posedge clk) begin
    if (pre_we) mem1[pre_idx] <= pre_dat;
    else if (dwe1) mem1[daddr1[11:2]] <= dwdata1;
    drdata1 <= mem1[daddr1[11:2]];
  end

  // ---------------- dut3: RD_LATENCY = 3 ----------------
  logic        rst3 = 1'b0;
  logic [1:0]  req3 = '0, we3 = '0;
  logic [63:0] addr3 = '0, wdata3 = '0;
  logic [1:0]  gnt3, rvalid3;
  logic [31:0] rdata3, daddr3, dwdata3, drdata3;
  logic        dwe3, busy3;
  logic [31:0] mem3 [0:1023];
  logic [31:0] pipe3 [0:2];

  ram_host_arbiter #(.NR_HOSTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .host_req_i(req3), .host_we_i(we3),
    .host_addr_i(addr3), .host_wdata_i(wdata3), .host_gnt_o(gnt3),
    .host_rvalid_o(rvalid3), .host_rdata_o(rdata3), .dev_we_o(dwe3),
    .dev_addr_o(daddr3), .dev_wdata_o(dwdata3), .dev_rdata_i(drdata3),
    .busy_o(busy3)
  );

  always @(posedge clk) begin
    if (pre_we) mem3[pre_idx] <= pre_dat;
    else if (dwe3) mem3[daddr3[11:2]] <= dwdata3;
    pipe3[0] <= mem3[daddr3[11:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign drdata3 = pipe3[2];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    pre_we  = 1'b1;
    pre_idx = 10'h010;            // byte address 0x40
    pre_dat = 32'hDEADBEEF;
    next_cycle();
    pre_idx = 10'h040;            // byte address 0x100
    pre_dat = 32'hCAFEF00D;
    next_cycle();
    pre_we  = 1'b0;
  endtask

  task automatic test_reset();
    req1 = 2'b11;
    addr1[0 +: 32]  = 32'h0000_0100;
    addr1[32 +: 32] = 32'h0000_0040;
    wdata1 = {32'h1111_1111, 32'h2222_2222};
    we1 = 2'b11;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt1); end
    n_cmp++; if (dwe1 !== 1'b0) begin n_bad++; $display("FAIL reset_dwe: got %b want 0", dwe1); end
    n_cmp++; if (daddr1 !== 32'h0) begin n_bad++; $display("FAIL reset_daddr: got %h want 0", daddr1); end
    n_cmp++; if (dwdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_dwdata: got %h want 0", dwdata1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_cmp++; if (rvalid1 !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid1); end
    n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata1); end
    next_cycle();
    we1  = 2'b00;
    rst1 = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b01) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 01", gnt1); end
    n_cmp++; if (daddr1 !== 32'h100) begin n_bad++; $display("FAIL reset_first_addr: got %h want 100", daddr1); end
    next_cycle();
    req1 = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid1 !== 2'b01) begin n_bad++; $display("FAIL reset_first_rvalid: got %b want 01", rvalid1); end
    $display("txn reset: first grant host 0 gnt=%b rvalid=%b", 2'b01, rvalid1);
    next_cycle();
  endtask

  // rr_ptr is 1 here, host 1 reads 0x40
  task automatic test_single_read();
    req1 = 2'b10; we1 = 2'b00;
    addr1[32 +: 32] = 32'h0000_0040;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b10) begin n_bad++; $display("FAIL rd_gnt: got %b want 10", gnt1); end
    n_cmp++; if (daddr1 !== 32'h40) begin n_bad++; $display("FAIL rd_daddr: got %h want 40", daddr1); end
    n_cmp++; if (dwe1 !== 1'b0) begin n_bad++; $display("FAIL rd_dwe: got %b want 0", dwe1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rd_busy_t: got %b want 0", busy1); end
    next_cycle();
    req1 = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid1 !== 2'b10) begin n_bad++; $display("FAIL rd_rvalid: got %b want 10", rvalid1); end
    n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", rdata1); end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL rd_busy_t1: got %b want 1", busy1); end
    n_cmp++; if (daddr1 !== 32'h40) begin n_bad++; $display("FAIL rd_addr_hold: got %h want 40", daddr1); end
    $display("txn read host1 addr=40 data=%h", rdata1);
    next_cycle();
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rd_busy_t2: got %b want 0", busy1); end
    n_cmp++; if (rvalid1 !== 2'b00) begin n_bad++; $display("FAIL rd_rvalid_t2: got %b want 00", rvalid1); end
    next_cycle();
  endtask

  // rr_ptr is 0 here; host 0 writes then reads 0x100 in 4 cycles
  task automatic test_write_read();
    req1 = 2'b01; we1 = 2'b01;
    addr1[0 +: 32]  = 32'h0000_0100;
    wdata1[0 +: 32] = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b01) begin n_bad++; $display("FAIL wr_gnt: got %b want 01", gnt1); end
    n_cmp++; if (dwe1 !== 1'b1) begin n_bad++; $display("FAIL wr_dwe: got %b want 1", dwe1); end
    n_cmp++; if (dwdata1 !== 32'h12345678) begin n_bad++; $display("FAIL wr_dwdata: got %h want 12345678", dwdata1); end
    next_cycle();
    we1 = 2'b00;
    wdata1[0 +: 32] = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (dwe1 !== 1'b0) begin n_bad++; $display("FAIL wr_dwe_wait: got %b want 0", dwe1); end
    n_cmp++; if (rvalid1 !== 2'b01) begin n_bad++; $display("FAIL wr_rvalid: got %b want 01", rvalid1); end
    n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0", rdata1); end
    n_cmp++; if (gnt1 !== 2'b00) begin n_bad++; $display("FAIL wr_no_gnt_wait: got %b want 00", gnt1); end
    $display("txn write host0 addr=100 data=12345678");
    next_cycle();
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b01) begin n_bad++; $display("FAIL wrrd_gnt: got %b want 01", gnt1); end
    n_cmp++; if (dwe1 !== 1'b0) begin n_bad++; $display("FAIL wrrd_dwe: got %b want 0", dwe1); end
    next_cycle();
    req1 = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid1 !== 2'b01) begin n_bad++; $display("FAIL wrrd_rvalid: got %b want 01", rvalid1); end
    n_cmp++; if (rdata1 !== 32'h12345678) begin n_bad++; $display("FAIL wrrd_rdata: got %h want 12345678", rdata1); end
    $display("txn read host0 addr=100 data=%h", rdata1);
    next_cycle();
  endtask

  // rr_ptr becomes 1 after this grant; reset in WAIT must drop the read and
  // bring rr_ptr back to 0.
  task automatic test_reset_mid();
    req1 = 2'b01; we1 = 2'b00;
    addr1[0 +: 32] = 32'h0000_0040;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 2'b01) begin n_bad++; $display("FAIL rm_gnt: got %b want 01", gnt1); end
    next_cycle();
    req1 = 2'b00;
    #1;
    rst1 = 1'b0;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy1); end
    n_cmp++; if (rvalid1 !== 2'b00) begin n_bad++; $display("FAIL rm_rvalid: got %b want 00", rvalid1); end
    next_cycle();
    n_cmp++; if (rvalid1 !== 2'b00) begin n_bad++; $display("FAIL rm_rvalid_after: got %b want 00", rvalid1); end
    rst1 = 1'b1;
    $display("txn reset during wait: read host0 aborted");
  endtask

  // Both hosts request continuously: 0,1,0,1,0,1, one grant every 2 cycles.
  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [1:0]  last_gnt;
    logic [31:0] exp_data;
    req1 = 2'b11; we1 = 2'b00;
    addr1[0 +: 32]  = 32'h0000_0100;
    addr1[32 +: 32] = 32'h0000_0040;
    last_gnt = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        exp_gnt = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (gnt1 !== exp_gnt) begin n_bad++; $display("FAIL cont_gnt k=%0d: got %b want %b", k, gnt1, exp_gnt); end
        last_gnt = exp_gnt;
      end else begin
        exp_data = (last_gnt == 2'b01) ? 32'h12345678 : 32'hDEADBEEF;
        n_cmp++; if (gnt1 !== 2'b00) begin n_bad++; $display("FAIL cont_nognt k=%0d: got %b want 00", k, gnt1); end
        n_cmp++; if (rvalid1 !== last_gnt) begin n_bad++; $display("FAIL cont_rvalid k=%0d: got %b want %b", k, rvalid1, last_gnt); end
        n_cmp++; if (rdata1 !== exp_data) begin n_bad++; $display("FAIL cont_rdata k=%0d: got %h want %h", k, rdata1, exp_data); end
        $display("txn contention host%0d data=%h", (last_gnt == 2'b01) ? 0 : 1, rdata1);
      end
      if ($countones(gnt1) > 1) begin
        n_cmp++; n_bad++; $display("FAIL cont_onehot k=%0d: got %b want at most one bit", k, gnt1);
      end
      next_cycle();
      if (k == 10) req1 = 2'b00;
    end
  endtask

  // RD_LATENCY=3: rvalid 3 cycles after gnt; host 1 raised during WAIT is
  // granted in the cycle right after that rvalid.
  task automatic test_latency();
    rst3 = 1'b1;
    next_cycle();
    req3 = 2'b01; we3 = 2'b00;
    addr3[0 +: 32]  = 32'h0000_0040;
    addr3[32 +: 32] = 32'h0000_0100;
    @(negedge clk);
    n_cmp++; if (gnt3 !== 2'b01) begin n_bad++; $display("FAIL lat_gnt0: got %b want 01", gnt3); end
    next_cycle();
    req3 = 2'b10;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (rvalid3 !== 2'b00) begin n_bad++; $display("FAIL lat_early_rvalid c=%0d: got %b want 00", c, rvalid3); end
      n_cmp++; if (gnt3 !== 2'b00) begin n_bad++; $display("FAIL lat_wait_gnt c=%0d: got %b want 00", c, gnt3); end
      n_cmp++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL lat_busy c=%0d: got %b want 1", c, busy3); end
      n_cmp++; if (daddr3 !== 32'h40) begin n_bad++; $display("FAIL lat_addr_hold c=%0d: got %h want 40", c, daddr3); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 2'b01) begin n_bad++; $display("FAIL lat_rvalid0: got %b want 01", rvalid3); end
    n_cmp++; if (rdata3 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat_rdata0: got %h want deadbeef", rdata3); end
    n_cmp++; if (gnt3 !== 2'b00) begin n_bad++; $display("FAIL lat_gnt_at_rvalid: got %b want 00", gnt3); end
    $display("txn latency3 read host0 addr=40 data=%h", rdata3);
    next_cycle();
    @(negedge clk);
    n_cmp++; if (gnt3 !== 2'b10) begin n_bad++; $display("FAIL lat_gnt1: got %b want 10", gnt3); end
    next_cycle();
    req3 = 2'b00;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (rvalid3 !== 2'b00) begin n_bad++; $display("FAIL lat1_early_rvalid c=%0d: got %b want 00", c, rvalid3); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 2'b10) begin n_bad++; $display("FAIL lat_rvalid1: got %b want 10", rvalid3); end
    n_cmp++; if (rdata3 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lat_rdata1: got %h want cafef00d", rdata3); end
    $display("txn latency3 read host1 addr=100 data=%h", rdata3);
    next_cycle();
  endtask

  initial begin
    #1;
    preload();
    test_reset();
    test_single_read();
    test_write_read();
    test_reset_mid();
    test_contention();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
